// File: rtl/bin2bcd_if.sv
// bin2bcd_if
//    Handshake and result bundle for the sequential binary-to-BCD converter.
//    The master is the upstream producer. It drives start and bin, and it
//    receives ready, done_tick, bcd and digit_en.
//    The slave is the converter, which drives the opposite direction.
//
//    Signals:
//       start     - conversion request, honoured only while ready=1
//       bin       - unsigned binary value, BIN_W bits
//       ready     - converter idle and able to accept start
//       done_tick - one-cycle completion pulse
//       bcd       - packed BCD result, digit 0 in bits [3:0]
//       digit_en  - leading-zero blanking mask, bit d = digit d lit
interface bin2bcd_if #(
   parameter int BIN_W  = 20,
   parameter int DIGITS = 7
);
   logic                  start;
   logic [BIN_W-1:0]      bin;
   logic                  ready;
   logic                  done_tick;
   logic [4*DIGITS-1:0]   bcd;
   logic [DIGITS-1:0]     digit_en;

   modport master (
      output start,
      output bin,
      input  ready,
      input  done_tick,
      input  bcd,
      input  digit_en
   );

   modport slave (
      input  start,
      input  bin,
      output ready,
      output done_tick,
      output bcd,
      output digit_en
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//    Sequential double-dabble converter. It turns an unsigned BIN_W-bit value
//    into DIGITS packed BCD digits and a leading-zero blanking mask.
//    A conversion takes BIN_W shift cycles plus one DONE cycle.
//    The bcd and digit_en outputs are loaded only on the completion edge, so a
//    downstream display never sees intermediate shift values.
//
//    Ports:
//       clk     - clock
//       reset_n - asynchronous active-low reset
//       bus     - bin2bcd_if slave modport
//                 (start/bin in; ready/done_tick/bcd/digit_en out)
module bin2bcd_seq #(
   parameter int BIN_W  = 20,
   parameter int DIGITS = 7
) (
   input  logic            clk,
   input  logic            reset_n,
   bin2bcd_if.slave        bus
);

   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int CAT_W = 4 * DIGITS + BIN_W;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OP   = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Add 3 to every digit that is 5 or more. All digits use their pre-shift
   // values. The digit is at most 9, so the 4-bit add cannot overflow.
   function automatic logic [4*DIGITS-1:0] dd_adjust(input logic [4*DIGITS-1:0] work);
      logic [4*DIGITS-1:0] res;
      logic [3:0]          dig;
      res = work;
      for (int d = 0; d < DIGITS; d++) begin
         dig = work[4*d +: 4];
         if (dig >= 4'd5) begin
            res[4*d +: 4] = dig + 4'd3;
         end else begin
            res[4*d +: 4] = dig;
         end
      end
      return res;
   endfunction

   // A digit is lit if it or any higher digit is non-zero.
   // Digit 0 is always lit, so a value of zero shows as a single "0".
   function automatic logic [DIGITS-1:0] lit_mask(input logic [4*DIGITS-1:0] val);
      logic [DIGITS-1:0] en;
      logic              seen;
      seen = 1'b0;
      for (int d = DIGITS - 1; d >= 0; d--) begin
         seen  = seen | (val[4*d +: 4] != 4'd0);
         en[d] = seen | (d == 0);
      end
      return en;
   endfunction

   logic [1:0]           state_r;
   logic [1:0]           state_nxt_s;
   logic [BIN_W-1:0]     bin_shift_r;
   logic [4*DIGITS-1:0]  bcd_work_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [4*DIGITS-1:0]  bcd_r;
   logic [DIGITS-1:0]    digit_en_r;

   logic [4*DIGITS-1:0]  adj_s;
   logic [CAT_W-1:0]     shifted_s;
   logic [4*DIGITS-1:0]  work_nxt_s;
   logic [BIN_W-1:0]     bin_nxt_s;
   logic                 last_s;

   // One double-dabble step: adjust the digits, then shift {digits, binary} left by one.
   always_comb begin
      adj_s      = dd_adjust(bcd_work_r);
      shifted_s  = {adj_s, bin_shift_r} << 1;
      work_nxt_s = shifted_s[CAT_W-1:BIN_W];
      bin_nxt_s  = shifted_s[BIN_W-1:0];
      last_s     = (cnt_r == CNT_W'(1));
   end

   // Next-state decode. Any unused encoding falls back to IDLE.
   always_comb begin
      state_nxt_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (bus.start) begin
               state_nxt_s = ST_OP;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_OP: begin
            if (last_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_OP;
            end
         end
         ST_DONE: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register and datapath registers. The outputs load only on the final OP edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         bin_shift_r <= '0;
         bcd_work_r  <= '0;
         cnt_r       <= '0;
         bcd_r       <= '0;
         digit_en_r  <= DIGITS'(1);
      end else begin
         state_r <= state_nxt_s;
         case (state_r)
            ST_IDLE: begin
               if (bus.start) begin
                  bin_shift_r <= bus.bin;
                  bcd_work_r  <= '0;
                  cnt_r       <= CNT_W'(BIN_W);
               end
            end
            ST_OP: begin
               bin_shift_r <= bin_nxt_s;
               bcd_work_r  <= work_nxt_s;
               cnt_r       <= cnt_r - CNT_W'(1);
               if (last_s) begin
                  bcd_r      <= work_nxt_s;
                  digit_en_r <= lit_mask(work_nxt_s);
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign bus.ready     = (state_r == ST_IDLE);
   assign bus.done_tick = (state_r == ST_DONE);
   assign bus.bcd       = bcd_r;
   assign bus.digit_en  = digit_en_r;

endmodule
